// File: rtl/wah_pkg.sv
// Shared types and defaults for the wah effect path.
//   wah_state_e : sweep controller load sequencer states
//   bank_w()    : bank index width for a given bank count
//   WAH_*       : default FIR geometry shared with the wah top
package wah_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WAIT_SWAP} wah_state_e;

  localparam int WAH_NUM_TAPS   = 61;
  localparam int WAH_COEF_WIDTH = 8;

  function automatic int bank_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/wah_lfo.sv
// Sample-rate triangle LFO for the wah sweep.
//   clk, rst (async, active-low), en, vld_i : accumulator advances by rate on
//                                             each sample strobe while enabled
//   rate [RATE_WIDTH]                      : phase increment per sample
//   want [BANK_W]                          : bank selected by the triangle
module wah_lfo #(
  parameter int RATE_WIDTH = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int BANK_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  vld_i,
  input  logic [RATE_WIDTH-1:0] rate,
  output logic [BANK_W-1:0]     want
);

  logic [ACC_WIDTH-1:0] acc;

  // rate=0 holds acc without a separate condition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              acc <= '0;
    else if (vld_i && en)  acc <= acc + {{(ACC_WIDTH-RATE_WIDTH){1'b0}}, rate};
  end

  // Fold the sawtooth into a triangle: the upper half of the phase counts
  // back down, so the bank index is continuous across acc wrap. Only the top
  // BANK_W bits of the fold are needed, and inversion is per-bit.
  assign want = acc[ACC_WIDTH-1] ? ~acc[ACC_WIDTH-2 -: BANK_W]
                                 :  acc[ACC_WIDTH-2 -: BANK_W];

endmodule

// File: rtl/wah_sweep_ctrl.sv
// Wah sweep controller: picks an FIR coefficient bank from the LFO, streams it
// from the coefficient ROM into the FIR shadow registers, then commits it with
// a swap pulse on a sample boundary.
//   clk, rst (async, active-low)
//   en           : sweep enable
//   rate         : LFO phase increment per sample
//   vld_i        : sample strobe shared with the FIR
//   rom_addr     : {bank, tap} ROM address, ROM returns data one cycle later
//   rom_data     : ROM read data
//   coef_wr_en/idx/data : shadow register write port
//   coef_swap    : one-cycle shadow->active commit
//   busy         : load in progress (start of load until swap)
//   bank_o       : bank currently active in the FIR
module wah_sweep_ctrl
  import wah_pkg::*;
#(
  parameter int NUM_TAPS   = WAH_NUM_TAPS,
  parameter int COEF_WIDTH = WAH_COEF_WIDTH,
  parameter int NUM_BANKS  = 16,
  parameter int RATE_WIDTH = 16,
  parameter int ACC_WIDTH  = 24,
  localparam int BANK_W    = bank_w(NUM_BANKS),
  localparam int TAP_W     = $clog2(NUM_TAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [RATE_WIDTH-1:0]   rate,
  input  logic                    vld_i,
  output logic [BANK_W+TAP_W-1:0] rom_addr,
  input  logic [COEF_WIDTH-1:0]   rom_data,
  output logic                    coef_wr_en,
  output logic [TAP_W-1:0]        coef_wr_idx,
  output logic [COEF_WIDTH-1:0]   coef_wr_data,
  output logic                    coef_swap,
  output logic                    busy,
  output logic [BANK_W-1:0]       bank_o
);

  logic [BANK_W-1:0] want;

  wah_lfo #(
    .RATE_WIDTH (RATE_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .BANK_W     (BANK_W)
  ) u_lfo (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .vld_i (vld_i),
    .rate  (rate),
    .want  (want)
  );

  wah_state_e        state, state_n;
  logic [TAP_W-1:0]  k, k_n, wr_idx_q, wr_idx_n;
  logic [BANK_W-1:0] tgt, tgt_n, bank_q, bank_n;
  logic              init_q, init_n;  // post-reset load still pending its swap
  logic              wr_en_q, wr_en_n, swap_q, swap_n, busy_q, busy_n;
  logic              abort;

  // Dropping en cancels a sweep load, but the post-reset load must always
  // land so the FIR never runs without a committed bank.
  assign abort = !init_q && !en && (state != IDLE);

  always_comb begin
    state_n = state;
    k_n     = k;
    tgt_n   = tgt;
    bank_n  = bank_q;
    init_n  = init_q;
    swap_n  = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:
          if (en && want != bank_q) begin
            tgt_n   = want;
            k_n     = '0;
            state_n = FETCH;
          end
        FETCH:
          if (k == TAP_W'(NUM_TAPS-1)) state_n = DRAIN;
          else                         k_n     = k + TAP_W'(1);
        // Last ROM word is arriving; its write is on the output this cycle.
        DRAIN:
          state_n = WAIT_SWAP;
        // Only a strobe seen in this state commits, so a strobe coinciding
        // with DRAIN never swaps in a set whose last write is still in flight.
        WAIT_SWAP:
          if (vld_i) begin
            swap_n  = 1'b1;
            bank_n  = tgt;
            init_n  = 1'b0;
            state_n = IDLE;
          end
      endcase
    end
    // The write trails the address by the ROM latency.
    wr_en_n  = (state == FETCH) && !abort;
    wr_idx_n = k;
    busy_n   = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      k        <= '0;
      tgt      <= '0;
      bank_q   <= '0;
      init_q   <= 1'b1;
      wr_en_q  <= 1'b0;
      wr_idx_q <= '0;
      swap_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      k        <= k_n;
      tgt      <= tgt_n;
      bank_q   <= bank_n;
      init_q   <= init_n;
      wr_en_q  <= wr_en_n;
      wr_idx_q <= wr_idx_n;
      swap_q   <= swap_n;
      busy_q   <= busy_n;
    end
  end

  assign rom_addr     = {tgt, k};
  assign coef_wr_en   = wr_en_q;
  assign coef_wr_idx  = wr_idx_q;
  assign coef_wr_data = wr_en_q ? rom_data : '0;
  assign coef_swap    = swap_q;
  assign busy         = busy_q;
  assign bank_o       = bank_q;

endmodule

// File: tb/tb_wah_sweep_ctrl.sv
module tb_wah_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [15:0] rate = '0;
  logic       vld_i = 1'b0;
  logic [9:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic       coef_wr_en;
  logic [5:0] coef_wr_idx;
  logic [7:0] coef_wr_data;
  logic       coef_swap;
  logic       busy;
  logic [3:0] bank_o;

  wah_sweep_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .rate(rate), .vld_i(vld_i),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .coef_wr_en(coef_wr_en), .coef_wr_idx(coef_wr_idx), .coef_wr_data(coef_wr_data),
    .coef_swap(coef_swap), .busy(busy), .bank_o(bank_o)
  );

  always #5 clk = ~clk;

  // ROM content = low 8 bits of its address, one-cycle read latency.
  always @(posedge clk) rom_data <= rom_addr[7:0];

  int n_vec = 0, n_bad = 0;
  int n_wr = 0, wr_sum = 0, last_idx = -1, n_swap = 0;
  int swq[$];
  int vper = 0, cyc_cnt = 0;

  // Behavioural model: load progress as "cycles since load entry"
  int m_acc, m_bank, m_tgt, m_lt, m_wait, m_init, m_busy, m_swap;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
    vld_i = (vper != 0) && (cyc_cnt % vper == 0);
    cyc_cnt++;
  endtask

  task automatic wait_busy(input string nm, input int v);
    int i;
    i = 0;
    while (i < 500 && busy !== v[0]) begin
      tick(); @(negedge clk); #1;
      i++;
    end
    chk(nm, busy, v);
  endtask

  function automatic int want_of(input int a);
    int t;
    t = (a < 2**23) ? a : (2**24 - 1 - a);
    return t / 2**19;
  endfunction

  initial begin
    int s_wr, s_sw, s_bank, ev;
    fork
      forever begin
        @(posedge clk);
        if (!rst) begin
          m_acc = 0; m_bank = 0; m_tgt = 0; m_lt = 0; m_wait = 0;
          m_init = 1; m_busy = 0; m_swap = 0;
        end else begin
          int wv;
          wv = want_of(m_acc);
          m_swap = 0;
          if ((m_lt >= 0 || m_wait != 0) && m_init == 0 && !en) begin
            m_lt = -1; m_wait = 0;
          end else if (m_lt >= 0) begin
            if (m_lt == 61) begin m_lt = -1; m_wait = 1; end
            else m_lt++;
          end else if (m_wait != 0) begin
            if (vld_i) begin m_swap = 1; m_bank = m_tgt; m_wait = 0; m_init = 0; end
          end else if (en && wv != m_bank) begin
            m_tgt = wv; m_lt = 0;
          end
          if (vld_i && en) m_acc = (m_acc + int'(rate)) % 2**24;
          m_busy = (m_lt >= 0 || m_wait != 0) ? 1 : 0;
        end
        @(negedge clk);
        if (!rst) begin
          chk("reset_zero", int'({rom_addr, coef_wr_en, coef_wr_idx, coef_wr_data,
                                  coef_swap, busy, bank_o}), 0);
        end else begin
          ev = (m_lt >= 1 && m_lt <= 61) ? 1 : 0;
          chk("wr_en", coef_wr_en, ev);
          if (ev != 0) begin
            chk("wr_idx", coef_wr_idx, m_lt - 1);
            chk("wr_data", coef_wr_data, (m_tgt * 64 + m_lt - 1) % 256);
          end
          if (m_lt >= 0 && m_lt <= 60) chk("rom_addr", rom_addr, m_tgt * 64 + m_lt);
          chk("swap", coef_swap, m_swap);
          chk("busy", busy, m_busy);
          chk("bank", bank_o, m_bank);
          if (coef_wr_en) begin n_wr++; wr_sum += coef_wr_data; last_idx = coef_wr_idx; end
          if (coef_swap) begin n_swap++; swq.push_back(int'(bank_o)); end
        end
      end
    join_none

    // T1: reset release with en=0 forces a bank-0 load and swap
    repeat (3) tick();
    rst = 1'b1;
    repeat (70) tick();
    @(negedge clk); #1;
    chk("t1_nwr", n_wr, 61);
    chk("t1_sum", wr_sum, 1830);
    chk("t1_last_idx", last_idx, 60);
    chk("t1_no_swap_yet", n_swap, 0);
    chk("t1_busy_wait", busy, 1);
    vper = 8;
    repeat (20) tick();
    @(negedge clk); #1;
    chk("t1_swap", n_swap, 1);
    chk("t1_bank", bank_o, 0);
    chk("t1_busy_done", busy, 0);

    // T6: rate=0 keeps the sweep parked
    en = 1'b1; rate = 16'h0000; vper = 4;
    s_wr = n_wr; s_sw = n_swap;
    repeat (4000) tick();
    @(negedge clk); #1;
    chk("t6_no_wr", n_wr - s_wr, 0);
    chk("t6_no_swap", n_swap - s_sw, 0);
    chk("t6_busy", busy, 0);

    // T2: full triangle period, one swap per bank step incl. wrap
    rate = 16'h8000; vper = 8;
    swq.delete();
    repeat (4196) tick();
    @(negedge clk); #1;
    chk("t2_nswaps", swq.size(), 30);
    for (int i = 0; i < 30; i++)
      chk("t2_swap_bank", (i < swq.size()) ? swq[i] : -1, 29 - i + ((i < 15) ? (2 * i - 28) : 0));

    // T3: faster strobes during loads
    vper = 4; s_sw = n_swap;
    repeat (600) tick();
    @(negedge clk); #1;
    chk("t3_swapped", (n_swap > s_sw) ? 1 : 0, 1);

    // T4: en dropped at k=30 of a sweep load
    vper = 8;
    wait_busy("t4_idle", 0);
    wait_busy("t4_start", 1);
    s_wr = n_wr; s_sw = n_swap; s_bank = m_bank;
    repeat (30) tick();
    en = 1'b0;
    repeat (10) tick();
    @(negedge clk); #1;
    chk("t4_nwr", n_wr - s_wr, 30);
    chk("t4_no_swap", n_swap - s_sw, 0);
    chk("t4_bank", bank_o, s_bank);
    chk("t4_busy", busy, 0);
    repeat (30) tick();

    // T5: reset at k=20 restarts the bank-0 load
    en = 1'b1;
    wait_busy("t5_start", 1);
    repeat (20) tick();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk); #1;
    chk("t5_k0_wr", coef_wr_en, 0);
    chk("t5_k0_busy", busy, 0);
    tick();
    @(negedge clk); #1;
    chk("t5_first_wr", coef_wr_en, 1);
    chk("t5_first_idx", coef_wr_idx, 0);
    chk("t5_first_data", coef_wr_data, 0);
    chk("t5_busy", busy, 1);
    s_sw = n_swap;
    repeat (100) tick();
    @(negedge clk); #1;
    chk("t5_swap", n_swap - s_sw, 1);
    chk("t5_bank", bank_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
